// File: rtl/decode_stage_if.sv
// Decode-stage bus: fetch handshake in, decoded instruction and execute
// handshake out, plus the writeback port that releases scoreboard entries.
interface decode_stage_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32
);
   logic                  i_flush;
   logic                  i_valid;
   logic                  o_ready;
   logic [DATA_WIDTH-1:0] i_inst;
   logic [ADDR_WIDTH-1:0] i_pc;
   logic                  o_valid;
   logic                  i_ready;
   logic [ADDR_WIDTH-1:0] o_pc;
   logic [6:0]            o_opcode;
   logic [6:0]            o_func7;
   logic [2:0]            o_func3;
   logic [4:0]            o_rs1_idx;
   logic [4:0]            o_rs2_idx;
   logic [4:0]            o_rd_idx;
   logic                  o_rs1_fp;
   logic                  o_rs2_fp;
   logic                  o_rd_wen;
   logic                  o_fd_wen;
   logic [DATA_WIDTH-1:0] o_imm;
   logic                  o_illegal;
   logic                  i_wb_valid;
   logic                  i_wb_fp;
   logic [4:0]            i_wb_idx;

   modport slave (
      input  i_flush, i_valid, i_inst, i_pc, i_ready, i_wb_valid, i_wb_fp, i_wb_idx,
      output o_ready, o_valid, o_pc, o_opcode, o_func7, o_func3, o_rs1_idx, o_rs2_idx,
             o_rd_idx, o_rs1_fp, o_rs2_fp, o_rd_wen, o_fd_wen, o_imm, o_illegal
   );

   modport master (
      output i_flush, i_valid, i_inst, i_pc, i_ready, i_wb_valid, i_wb_fp, i_wb_idx,
      input  o_ready, o_valid, o_pc, o_opcode, o_func7, o_func3, o_rs1_idx, o_rs2_idx,
             o_rd_idx, o_rs1_fp, o_rs2_fp, o_rd_wen, o_fd_wen, o_imm, o_illegal
   );
endinterface

// File: rtl/decode_stage.sv
// One-entry RV32I + F-subset decode stage: decodes on accept, holds the
// result until execute takes it, and blocks issue while a source or
// destination register is still owned by an in-flight instruction.
module decode_stage #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32,
   parameter bit FP_EN      = 1'b1
) (
   input logic           i_clk,
   input logic           i_rst,
   decode_stage_if.slave bus
);
   localparam logic [6:0] OP_R     = 7'b0110011;
   localparam logic [6:0] OP_I     = 7'b0010011;
   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_S     = 7'b0100011;
   localparam logic [6:0] OP_B     = 7'b1100011;
   localparam logic [6:0] OP_JAL   = 7'b1101111;
   localparam logic [6:0] OP_JALR  = 7'b1100111;
   localparam logic [6:0] OP_LUI   = 7'b0110111;
   localparam logic [6:0] OP_AUIPC = 7'b0010111;
   localparam logic [6:0] OP_SYS   = 7'b1110011;
   localparam logic [6:0] OP_FP    = 7'b1010011;
   localparam logic [6:0] OP_FLW   = 7'b0000111;
   localparam logic [6:0] OP_FSW   = 7'b0100111;

   typedef enum logic {EMPTY, FULL} state_t;
   state_t state;

   logic [31:0] inst;
   logic [6:0]  op, f7;
   logic [2:0]  f3;
   logic is_r, is_i, is_load, is_s, is_b, is_jal, is_jalr, is_lui, is_auipc, is_sys;
   logic is_fpop, is_flw, is_fsw, fadd, fsub, flt, fclass;
   logic legal, use_rs1, use_rs2, use_rd, use_f3, use_f7;
   logic signed [31:0] imm32;

   logic [6:0]                   opcode_d, func7_d;
   logic [2:0]                   func3_d;
   logic [4:0]                   rs1_d, rs2_d, rd_d;
   logic                         rs1_fp_d, rs2_fp_d, rd_wen_d, fd_wen_d, illegal_d;
   logic signed [DATA_WIDTH-1:0] imm_d;

   logic [ADDR_WIDTH-1:0]        pc_p0;
   logic [6:0]                   opcode_p0, func7_p0;
   logic [2:0]                   func3_p0;
   logic [4:0]                   rs1_p0, rs2_p0, rd_p0;
   logic                         rs1_fp_p0, rs2_fp_p0, rd_wen_p0, fd_wen_p0, illegal_p0;
   logic signed [DATA_WIDTH-1:0] imm_p0;

   logic [31:0] busy_int_p0, busy_fp_p0, busy_int_nxt, busy_fp_nxt;
   logic        rs1_busy, rs2_busy, hazard, valid, fire, ready, accept;

   // Field decode of the incoming word; unused fields and illegal words read as 0
   always_comb begin
      inst     = bus.i_inst[31:0];
      op       = inst[6:0];
      f3       = inst[14:12];
      f7       = inst[31:25];
      is_r     = (op == OP_R);
      is_i     = (op == OP_I);
      is_load  = (op == OP_LOAD);
      is_s     = (op == OP_S);
      is_b     = (op == OP_B);
      is_jal   = (op == OP_JAL);
      is_jalr  = (op == OP_JALR);
      is_lui   = (op == OP_LUI);
      is_auipc = (op == OP_AUIPC);
      is_sys   = (op == OP_SYS);
      is_fpop  = FP_EN && (op == OP_FP);
      is_flw   = FP_EN && (op == OP_FLW);
      is_fsw   = FP_EN && (op == OP_FSW);
      fadd     = is_fpop && (f7 == 7'b0000000);
      fsub     = is_fpop && (f7 == 7'b0000100);
      flt      = is_fpop && (f7 == 7'b1010000) && (f3 == 3'b001);
      fclass   = is_fpop && (f7 == 7'b1110000) && (f3 == 3'b001);
      legal    = is_r | is_i | is_load | is_s | is_b | is_jal | is_jalr | is_lui | is_auipc |
                 is_sys | fadd | fsub | flt | fclass | is_flw | is_fsw;
      use_rs1  = is_r | is_i | is_load | is_s | is_b | is_jalr | is_sys |
                 fadd | fsub | flt | fclass | is_flw | is_fsw;
      use_rs2  = is_r | is_s | is_b | fadd | fsub | flt | is_fsw;
      use_rd   = legal && !(is_s | is_b | is_fsw);
      use_f3   = legal && !(is_lui | is_auipc | is_jal);
      use_f7   = is_r | fadd | fsub | flt | fclass;

      imm32 = '0;
      if (is_i | is_load | is_jalr | is_flw)
         imm32 = {{20{inst[31]}}, inst[31:20]};
      else if (is_s | is_fsw)
         imm32 = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      else if (is_b)
         imm32 = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      else if (is_jal)
         imm32 = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      else if (is_lui | is_auipc)
         imm32 = {inst[31:12], 12'b0};

      opcode_d  = op;
      func7_d   = use_f7 ? f7 : 7'd0;
      func3_d   = use_f3 ? f3 : 3'd0;
      rs1_d     = use_rs1 ? inst[19:15] : 5'd0;
      rs2_d     = use_rs2 ? inst[24:20] : 5'd0;
      rd_d      = use_rd ? inst[11:7] : 5'd0;
      rs1_fp_d  = fadd | fsub | flt | fclass;
      rs2_fp_d  = fadd | fsub | flt | is_fsw;
      fd_wen_d  = fadd | fsub | is_flw;
      rd_wen_d  = (is_r | is_i | is_load | is_jal | is_jalr | is_lui | is_auipc | flt | fclass) &&
                  (inst[11:7] != 5'd0);
      imm_d     = DATA_WIDTH'(imm32);
      illegal_d = !legal;
   end

   // Hazard check against registered busy bits, handshake, and next scoreboard
   always_comb begin
      rs1_busy = rs1_fp_p0 ? busy_fp_p0[rs1_p0] : busy_int_p0[rs1_p0];
      rs2_busy = rs2_fp_p0 ? busy_fp_p0[rs2_p0] : busy_int_p0[rs2_p0];
      hazard   = rs1_busy | rs2_busy | (rd_wen_p0 & busy_int_p0[rd_p0]) |
                 (fd_wen_p0 & busy_fp_p0[rd_p0]);
      valid    = (state == FULL) && !hazard && !bus.i_flush;
      fire     = valid && bus.i_ready;
      ready    = !bus.i_flush && ((state == EMPTY) || fire);
      accept   = bus.i_valid && ready;

      busy_int_nxt = busy_int_p0;
      busy_fp_nxt  = busy_fp_p0;
      if (bus.i_wb_valid) begin
         if (bus.i_wb_fp) busy_fp_nxt[bus.i_wb_idx]  = 1'b0;
         else             busy_int_nxt[bus.i_wb_idx] = 1'b0;
      end
      // applied after the clear so a same-cycle set on the same bit wins
      if (fire && rd_wen_p0) busy_int_nxt[rd_p0] = 1'b1;
      if (fire && fd_wen_p0) busy_fp_nxt[rd_p0]  = 1'b1;
      busy_int_nxt[0] = 1'b0;
   end

   // Holding-register state: flush empties, accept fills, lone fire drains
   always_ff @(posedge i_clk) begin
      if (i_rst)             state <= EMPTY;
      else if (bus.i_flush)  state <= EMPTY;
      else if (accept)       state <= FULL;
      else if (fire)         state <= EMPTY;
   end

   // Decoded fields captured only on accept, so they hold through any stall
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         pc_p0      <= '0;
         opcode_p0  <= '0;
         func7_p0   <= '0;
         func3_p0   <= '0;
         rs1_p0     <= '0;
         rs2_p0     <= '0;
         rd_p0      <= '0;
         rs1_fp_p0  <= 1'b0;
         rs2_fp_p0  <= 1'b0;
         rd_wen_p0  <= 1'b0;
         fd_wen_p0  <= 1'b0;
         illegal_p0 <= 1'b0;
         imm_p0     <= '0;
      end else if (accept) begin
         pc_p0      <= bus.i_pc;
         opcode_p0  <= opcode_d;
         func7_p0   <= func7_d;
         func3_p0   <= func3_d;
         rs1_p0     <= rs1_d;
         rs2_p0     <= rs2_d;
         rd_p0      <= rd_d;
         rs1_fp_p0  <= rs1_fp_d;
         rs2_fp_p0  <= rs2_fp_d;
         rd_wen_p0  <= rd_wen_d;
         fd_wen_p0  <= fd_wen_d;
         illegal_p0 <= illegal_d;
         imm_p0     <= imm_d;
      end
   end

   // Register scoreboard: set on issue, cleared by writeback, untouched by flush
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         busy_int_p0 <= '0;
         busy_fp_p0  <= '0;
      end else begin
         busy_int_p0 <= busy_int_nxt;
         busy_fp_p0  <= busy_fp_nxt;
      end
   end

   assign bus.o_ready   = ready;
   assign bus.o_valid   = valid;
   assign bus.o_pc      = pc_p0;
   assign bus.o_opcode  = opcode_p0;
   assign bus.o_func7   = func7_p0;
   assign bus.o_func3   = func3_p0;
   assign bus.o_rs1_idx = rs1_p0;
   assign bus.o_rs2_idx = rs2_p0;
   assign bus.o_rd_idx  = rd_p0;
   assign bus.o_rs1_fp  = rs1_fp_p0;
   assign bus.o_rs2_fp  = rs2_fp_p0;
   assign bus.o_rd_wen  = rd_wen_p0;
   assign bus.o_fd_wen  = fd_wen_p0;
   assign bus.o_imm     = imm_p0;
   assign bus.o_illegal = illegal_p0;
endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: an FP-enabled and an FP-disabled copy
// run in lockstep on the same stimulus; each has its own expected queue.
module tb_decode_stage;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   decode_stage_if ifa ();
   decode_stage_if ifb ();

   assign ifb.i_flush    = ifa.i_flush;
   assign ifb.i_valid    = ifa.i_valid;
   assign ifb.i_inst     = ifa.i_inst;
   assign ifb.i_pc       = ifa.i_pc;
   assign ifb.i_ready    = ifa.i_ready;
   assign ifb.i_wb_valid = ifa.i_wb_valid;
   assign ifb.i_wb_fp    = ifa.i_wb_fp;
   assign ifb.i_wb_idx   = ifa.i_wb_idx;

   decode_stage #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .FP_EN(1'b1)) dut_fp (
      .i_clk(clk), .i_rst(rst), .bus(ifa));
   decode_stage #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .FP_EN(1'b0)) dut_nofp (
      .i_clk(clk), .i_rst(rst), .bus(ifb));

   // flags = {rs1_fp, rs2_fp, rd_wen, fd_wen, illegal}
   typedef struct packed {
      logic [31:0] pc;
      logic [6:0]  op;
      logic [14:0] idx;
      logic [4:0]  flags;
      logic [31:0] imm;
   } exp_t;

   localparam logic [4:0] F_NONE = 5'b00000;
   localparam logic [4:0] F_INT  = 5'b00100;
   localparam logic [4:0] F_ILL  = 5'b00001;

   exp_t qa[$];
   exp_t qb[$];
   exp_t ea, eb;
   int tests  = 0;
   int failed = 0;
   logic [31:0] pc_next = 32'h0000_1000;

   function automatic exp_t mk(input logic [6:0] op, input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic [4:0] rd, input logic [4:0] flags, input logic [31:0] imm);
      exp_t r;
      r.pc    = 32'd0;
      r.op    = op;
      r.idx   = {rs1, rs2, rd};
      r.flags = flags;
      r.imm   = imm;
      return r;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Present one word; push expectations (FP-disabled copy sees FP words as illegal)
   task automatic send(input logic [31:0] inst, input exp_t e, input bit fp, input bit push,
                       input bit must_ready);
      exp_t eb_l;
      int n = 0;
      e.pc        = pc_next;
      ifa.i_inst  = inst;
      ifa.i_pc    = pc_next;
      ifa.i_valid = 1'b1;
      pc_next     = pc_next + 32'd4;
      @(negedge clk);
      if (must_ready) chk("stream_o_ready", 32'(ifa.o_ready), 32'd1);
      while (!ifa.o_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!ifa.o_ready) begin
         tests++;
         failed++;
         $display("FAIL accept_timeout: got o_ready=0 after 50 cycles, required 1 (inst 0x%08h)", inst);
      end else if (push) begin
         eb_l = e;
         if (fp) begin
            eb_l.idx   = 15'd0;
            eb_l.flags = F_ILL;
            eb_l.imm   = 32'd0;
         end
         qa.push_back(e);
         qb.push_back(eb_l);
      end
      step();
      ifa.i_valid = 1'b0;
   endtask

   task automatic wb(input logic fp, input logic [4:0] idx);
      ifa.i_wb_valid = 1'b1;
      ifa.i_wb_fp    = fp;
      ifa.i_wb_idx   = idx;
      step();
      ifa.i_wb_valid = 1'b0;
   endtask

   task automatic drain();
      for (int i = 0; i < 30 && (qa.size() != 0 || qb.size() != 0); i++) @(negedge clk);
      tests++;
      if (qa.size() != 0 || qb.size() != 0) begin
         failed++;
         $display("FAIL drain_timeout: got %0d/%0d pending outputs, required 0/0", qa.size(), qb.size());
      end
      step();
   endtask

   // Monitor for the FP-enabled copy
   always @(negedge clk) begin
      if (!rst && ifa.o_valid && ifa.i_ready) begin
         if (qa.size() == 0) begin
            tests++;
            failed++;
            $display("FAIL a_extra_fire: got output pc 0x%08h, required none", ifa.o_pc);
         end else begin
            ea = qa.pop_front();
            chk("a_pc", ifa.o_pc, ea.pc);
            chk("a_opcode", 32'(ifa.o_opcode), 32'(ea.op));
            chk("a_idx", 32'({ifa.o_rs1_idx, ifa.o_rs2_idx, ifa.o_rd_idx}), 32'(ea.idx));
            chk("a_flags", 32'({ifa.o_rs1_fp, ifa.o_rs2_fp, ifa.o_rd_wen, ifa.o_fd_wen, ifa.o_illegal}),
                32'(ea.flags));
            chk("a_imm", ifa.o_imm, ea.imm);
         end
      end
   end

   // Monitor for the FP-disabled copy
   always @(negedge clk) begin
      if (!rst && ifb.o_valid && ifb.i_ready) begin
         if (qb.size() == 0) begin
            tests++;
            failed++;
            $display("FAIL b_extra_fire: got output pc 0x%08h, required none", ifb.o_pc);
         end else begin
            eb = qb.pop_front();
            chk("b_pc", ifb.o_pc, eb.pc);
            chk("b_idx", 32'({ifb.o_rs1_idx, ifb.o_rs2_idx, ifb.o_rd_idx}), 32'(eb.idx));
            chk("b_flags", 32'({ifb.o_rs1_fp, ifb.o_rs2_fp, ifb.o_rd_wen, ifb.o_fd_wen, ifb.o_illegal}),
                32'(eb.flags));
            chk("b_imm", ifb.o_imm, eb.imm);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      ifa.i_flush    = 1'b0;
      ifa.i_valid    = 1'b0;
      ifa.i_inst     = 32'd0;
      ifa.i_pc       = 32'd0;
      ifa.i_ready    = 1'b1;
      ifa.i_wb_valid = 1'b0;
      ifa.i_wb_fp    = 1'b0;
      ifa.i_wb_idx   = 5'd0;
      rst            = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_o_valid", 32'(ifa.o_valid), 32'd0);
      chk("rst_o_ready", 32'(ifa.o_ready), 32'd1);
      chk("rst_o_pc", ifa.o_pc, 32'd0);
      chk("rst_o_imm", ifa.o_imm, 32'd0);
      chk("rst_o_illegal", 32'(ifa.o_illegal), 32'd0);
      chk("rst_o_rd_idx", 32'(ifa.o_rd_idx), 32'd0);
      step();

      // back-to-back stream, no dependence
      send(32'h002081B3, mk(7'h33, 5'd1, 5'd2, 5'd3, F_INT, 32'd0), 1'b0, 1'b1, 1'b1);
      send(32'hFFF00213, mk(7'h13, 5'd0, 5'd0, 5'd4, F_INT, 32'hFFFF_FFFF), 1'b0, 1'b1, 1'b1);
      drain();
      wb(1'b0, 5'd3);
      wb(1'b0, 5'd4);

      // RAW: sub x5,x3,x1 waits for x3 writeback, no same-cycle bypass
      send(32'h002081B3, mk(7'h33, 5'd1, 5'd2, 5'd3, F_INT, 32'd0), 1'b0, 1'b1, 1'b0);
      send(32'h401182B3, mk(7'h33, 5'd3, 5'd1, 5'd5, F_INT, 32'd0), 1'b0, 1'b1, 1'b0);
      repeat (4) begin
         @(negedge clk);
         chk("raw_stall_valid", 32'(ifa.o_valid), 32'd0);
         chk("raw_stall_ready", 32'(ifa.o_ready), 32'd0);
         step();
      end
      ifa.i_wb_valid = 1'b1;
      ifa.i_wb_fp    = 1'b0;
      ifa.i_wb_idx   = 5'd3;
      @(negedge clk);
      chk("raw_no_bypass", 32'(ifa.o_valid), 32'd0);
      step();
      ifa.i_wb_valid = 1'b0;
      drain();
      wb(1'b0, 5'd5);

      // set wins: x3 writeback in the same cycle add x3 issues
      send(32'h002081B3, mk(7'h33, 5'd1, 5'd2, 5'd3, F_INT, 32'd0), 1'b0, 1'b1, 1'b0);
      ifa.i_wb_valid = 1'b1;
      ifa.i_wb_fp    = 1'b0;
      ifa.i_wb_idx   = 5'd3;
      step();
      ifa.i_wb_valid = 1'b0;
      send(32'h40118333, mk(7'h33, 5'd3, 5'd1, 5'd6, F_INT, 32'd0), 1'b0, 1'b1, 1'b0);
      repeat (3) begin
         @(negedge clk);
         chk("setwins_stall", 32'(ifa.o_valid), 32'd0);
         step();
      end
      wb(1'b0, 5'd3);
      drain();
      wb(1'b0, 5'd6);

      // FP decode (illegal on the FP-disabled copy)
      send(32'h003100D3, mk(7'h53, 5'd2, 5'd3, 5'd1, 5'b11010, 32'd0), 1'b1, 1'b1, 1'b0);
      send(32'h0020A427, mk(7'h27, 5'd1, 5'd2, 5'd0, 5'b01000, 32'd8), 1'b1, 1'b1, 1'b0);
      drain();
      wb(1'b1, 5'd1);

      // immediates and an illegal opcode
      send(32'hFFDFF0EF, mk(7'h6F, 5'd0, 5'd0, 5'd1, F_INT, 32'hFFFF_FFFC), 1'b0, 1'b1, 1'b0);
      send(32'h00000863, mk(7'h63, 5'd0, 5'd0, 5'd0, F_NONE, 32'h0000_0010), 1'b0, 1'b1, 1'b0);
      send(32'h0000007F, mk(7'h7F, 5'd0, 5'd0, 5'd0, F_ILL, 32'd0), 1'b0, 1'b1, 1'b0);
      send(32'h123453B7, mk(7'h37, 5'd0, 5'd0, 5'd7, F_INT, 32'h1234_5000), 1'b0, 1'b1, 1'b0);
      send(32'hFF812403, mk(7'h03, 5'd2, 5'd0, 5'd8, F_INT, 32'hFFFF_FFF8), 1'b0, 1'b1, 1'b0);
      drain();
      wb(1'b0, 5'd1);
      wb(1'b0, 5'd7);
      wb(1'b0, 5'd8);

      // backpressure: outputs hold while i_ready=0, new input not taken
      ifa.i_ready = 1'b0;
      send(32'h002084B3, mk(7'h33, 5'd1, 5'd2, 5'd9, F_INT, 32'd0), 1'b0, 1'b1, 1'b0);
      ifa.i_valid = 1'b1;
      ifa.i_inst  = 32'hFFFF_FFFF;
      repeat (3) begin
         @(negedge clk);
         chk("bp_valid", 32'(ifa.o_valid), 32'd1);
         chk("bp_rd_idx", 32'(ifa.o_rd_idx), 32'd9);
         chk("bp_pc", ifa.o_pc, qa[0].pc);
         chk("bp_ready", 32'(ifa.o_ready), 32'd0);
         step();
      end
      ifa.i_valid = 1'b0;
      ifa.i_ready = 1'b1;
      drain();

      // flush while full; concurrent input rejected; scoreboard kept (x9 busy)
      ifa.i_ready = 1'b0;
      send(32'h00208533, mk(7'h33, 5'd1, 5'd2, 5'd10, F_INT, 32'd0), 1'b0, 1'b0, 1'b0);
      ifa.i_flush = 1'b1;
      ifa.i_valid = 1'b1;
      ifa.i_inst  = 32'h00100593;
      @(negedge clk);
      chk("flush_valid", 32'(ifa.o_valid), 32'd0);
      chk("flush_ready", 32'(ifa.o_ready), 32'd0);
      step();
      ifa.i_flush = 1'b0;
      ifa.i_valid = 1'b0;
      ifa.i_ready = 1'b1;
      repeat (2) begin
         @(negedge clk);
         chk("flush_empty", 32'(ifa.o_valid), 32'd0);
         step();
      end
      send(32'h00208533, mk(7'h33, 5'd1, 5'd2, 5'd10, F_INT, 32'd0), 1'b0, 1'b1, 1'b0);
      @(negedge clk);
      chk("flush_sb_x10_free", 32'(ifa.o_valid), 32'd1);
      step();
      send(32'h001486B3, mk(7'h33, 5'd9, 5'd1, 5'd13, F_INT, 32'd0), 1'b0, 1'b1, 1'b0);
      repeat (2) begin
         @(negedge clk);
         chk("flush_sb_x9_busy", 32'(ifa.o_valid), 32'd0);
         step();
      end
      wb(1'b0, 5'd9);
      drain();

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end
endmodule

// File: doc/decode_stage.md
# decode_stage

Registered, parametrised RV32I+F-subset instruction-decode stage with a valid/ready handshake, immediate generation, illegal-opcode detection and a per-register scoreboard that holds issue on RAW/WAW hazards. It sits between instruction fetch and execute in the core. It replaces the purely combinational field decoder with a one-entry pipeline stage that can stall and flush.

## Interface
- DATA_WIDTH, 32, instruction/immediate width (≥32); the immediate is sign-extended to DATA_WIDTH
- ADDR_WIDTH, 32, PC width
- FP_EN, 1, 1 enables the FP opcodes (OP-FP, FLW, FSW); 0 makes them illegal
- i_clk  in  1  clock; all state changes on the rising edge
- i_rst  in  1  synchronous, active-high reset
- i_flush  in  1  discard the held instruction (branch/jump redirect)
- i_valid  in  1  fetch presents an instruction
- o_ready  out  1  stage can accept this cycle
- i_inst  in  DATA_WIDTH  instruction word
- i_pc  in  ADDR_WIDTH  its PC
- o_valid  out  1  decoded instruction available and hazard-free
- i_ready  in  1  execute accepts
- o_pc  out  ADDR_WIDTH;  o_opcode  out  7;  o_func7  out  7;  o_func3  out  3
- o_rs1_idx / o_rs2_idx / o_rd_idx  out  5 each  source/destination indices
- o_rs1_fp / o_rs2_fp  out  1 each  source is read from the FP regfile
- o_rd_wen / o_fd_wen  out  1 each  write integer rd / FP fd
- o_imm  out  DATA_WIDTH  sign-extended immediate
- o_illegal  out  1  unsupported encoding
- i_wb_valid  in  1;  i_wb_fp  in  1;  i_wb_idx  in  5  writeback clears the scoreboard bit

## Operation
- Holding register: state EMPTY/FULL. Accept = i_valid && o_ready. Fire = o_valid && i_ready.
- o_ready = !i_flush && (EMPTY || fire).
- On accept, the fully decoded fields are registered and the state goes FULL. If fire happens without an accept, the state goes EMPTY.
- On i_flush, the state goes EMPTY and the input is not accepted. Flush has priority over accept and fire. The scoreboard is untouched by flush.
- Opcode classes:
  - R 0110011
  - I-ALU 0010011
  - LOAD 0000011
  - S 0100011
  - B 1100011
  - JAL 1101111
  - JALR 1100111
  - LUI 0110111
  - AUIPC 0010111
  - SYSTEM 1110011
  - OP-FP 1010011: fadd f7=0000000, fsub f7=0000100, flt f7=1010000/f3=001, fclass f7=1110000/f3=001
  - FLW 0000111
  - FSW 0100111
- Any other encoding, or an OP-FP funct combination not listed, sets o_illegal=1 and forces idx=0, wen=0, fp flags=0, imm=0. An illegal instruction still flows through the handshake.
- Fields not used by a class output 0: func7 outside R/OP-FP; rs2 for I/U/J; rd for S/B; rs1 for U/J.
- o_rs1_fp = fadd|fsub|flt|fclass. o_rs2_fp = fadd|fsub|flt|fsw.
- o_fd_wen = fadd|fsub|flw. o_rd_wen = R|I-ALU|LOAD|JAL|JALR|LUI|AUIPC|flt|fclass, and is forced to 0 when rd=0.
- Immediates:
  - I/LOAD/JALR/FLW: inst[31:20]
  - S/FSW: {inst[31:25],inst[11:7]}
  - B: {inst[31],inst[7],inst[30:25],inst[11:8],0}
  - J: {inst[31],inst[19:12],inst[20],inst[30:21],0}
  - U: {inst[31:12],12'b0}
  - All are sign-extended from inst[31] to DATA_WIDTH. Others are 0.
- Scoreboard: busy_int[31:0] and busy_fp[31:0]. busy_int[0] is constant 0.
- hazard = (rs1 used && busy[rs1_fp][rs1]) || (rs2 used && busy[rs2_fp][rs2]) || (rd_wen && busy_int[rd]) || (fd_wen && busy_fp[rd]).
- o_valid = FULL && !hazard && !i_flush.
- On fire, set the busy bit of the destination. On i_wb_valid, clear busy[i_wb_fp][i_wb_idx].
- If a set and a clear hit the same bit in the same cycle, set wins.

## Timing
- Latency is 1 cycle: an instruction accepted at edge N has outputs valid after edge N, provided there is no hazard.
- Throughput is 1 instruction/cycle with back-to-back accept and fire when there are no hazards.
- The hazard check uses registered busy bits. A writeback clear is visible on the cycle after i_wb_valid; there is no same-cycle bypass.
- While o_valid=0 or i_ready=0, all outputs are held stable.
- Reset values: state EMPTY, o_valid=0, all decoded outputs 0, o_pc=0, o_illegal=0, all busy bits 0. o_ready=1 in the first cycle after reset, unless i_flush is asserted.
- Reset mid-stall drops the held instruction and clears the scoreboard.

## Test plan
- Stream `add x3,x1,x2` (0x002081B3), then `addi x4,x0,-1` (0xFFF00213), with i_ready=1 and no dependence:
  - add on the cycle after accept: rd=3, rd_wen=1.
  - addi on the next cycle: imm=0xFFFFFFFF.
  - o_ready stays 1 throughout.
- RAW hazard: `add x3,..` fires, then `sub x5,x3,x1` is accepted.
  - o_valid=0 and o_ready=0 until 1 cycle after i_wb_valid with idx=3, fp=0; then the sub fires.
- Set wins: writeback of x3 in the same cycle the new `add x3` fires leaves busy_int[3]=1.
- FP decode: `fadd f1,f2,f3` (0x003100D3):
  - rs1_fp=1, rs2_fp=1, fd_wen=1, rd_wen=0.
  - `fsw f2,8(x1)` (0x0020A427): rs2_fp=1, imm=8.
  - With FP_EN=0, the same words give o_illegal=1.
- Immediates and illegal encodings:
  - `jal x1,-4` (0xFFDFF0EF) gives imm=0xFFFFFFFC.
  - `beq` with offset +16 gives imm=0x10.
  - Word 0x0000007F gives o_illegal=1, all wens=0.
- Flush and backpressure:
  - i_ready=0 holds the outputs unchanged for 3 cycles.
  - i_flush while FULL gives o_valid=0 the next cycle and the scoreboard unchanged.
  - A simultaneous i_valid during flush is not accepted.
